// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin fetch/data arbiter in front of one single-port SRAM
module core_mem_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TRANSFER_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      if_req_i,
    input  logic [ADDR_WIDTH-1:0]     if_addr_i,
    output logic                      if_gnt_o,
    output logic                      if_rvalid_o,
    output logic [DATA_WIDTH-1:0]     if_rdata_o,

    input  logic                      d_req_i,
    input  logic                      d_we_i,
    input  logic [TRANSFER_WIDTH-1:0] d_be_i,
    input  logic [ADDR_WIDTH-1:0]     d_addr_i,
    input  logic [DATA_WIDTH-1:0]     d_wdata_i,
    output logic                      d_gnt_o,
    output logic                      d_rvalid_o,
    output logic [DATA_WIDTH-1:0]     d_rdata_o,

    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [TRANSFER_WIDTH-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

    output logic                      busy_o
);

    // Owner of the read strobe issued in the previous cycle.
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PEND_IF = 2'd1,
        PEND_D  = 2'd2
    } pend_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

    pend_t                 state_q, state_d;
    grant_t                last_q, last_d;
    logic [DATA_WIDTH-1:0] if_hold_q;
    logic [DATA_WIDTH-1:0] d_hold_q;
    logic                  if_gnt;
    logic                  d_gnt;

    // Grant logic; gated by rst_n so nothing reaches the SRAM during reset.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n) begin
            if (if_req_i && d_req_i) begin
                if (last_q == GRANT_IF) begin
                    d_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end else if (if_req_i) begin
                if_gnt = 1'b1;
            end else if (d_req_i) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Memory request side.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (d_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_be_o    = d_we_i ? d_be_i : {TRANSFER_WIDTH{1'b1}};
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (if_gnt) begin
            mem_en_o    = 1'b1;
            mem_be_o    = {TRANSFER_WIDTH{1'b1}};
            mem_addr_o  = if_addr_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    // Next pending owner and round-robin pointer.
    always_comb begin
        state_d = NONE;
        last_d  = last_q;
        if (if_gnt) begin
            state_d = PEND_IF;
            last_d  = GRANT_IF;
        end else if (d_gnt) begin
            state_d = d_we_i ? NONE : PEND_D;
            last_d  = GRANT_D;
        end
    end

    // Async reset drops any in-flight read so its rvalid never appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= NONE;
            last_q    <= GRANT_IF;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            if (state_q == PEND_IF) begin
                if_hold_q <= mem_rdata_i;
            end
            if (state_q == PEND_D) begin
                d_hold_q <= mem_rdata_i;
            end
        end
    end

    // Response side: pass-through during the response cycle, hold afterwards.
    assign if_gnt_o    = if_gnt;
    assign d_gnt_o     = d_gnt;
    assign if_rvalid_o = (state_q == PEND_IF);
    assign d_rvalid_o  = (state_q == PEND_D);
    assign if_rdata_o  = (state_q == PEND_IF) ? mem_rdata_i : if_hold_q;
    assign d_rdata_o   = (state_q == PEND_D) ? mem_rdata_i : d_hold_q;
    assign busy_o      = (state_q != NONE);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed self-checking bench for core_mem_arbiter
`timescale 1ns/1ps
module tb_core_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_req, d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt_o, d_rvalid_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_en_o, mem_we_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata;
    logic          busy_o;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_q = '0;
    logic          rd_v = 1'b0;

    always #5 clk = ~clk;

    core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRANSFER_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
        .busy_o(busy_o)
    );

    // SRAM model: byte-enabled write, 1-cycle read; garbage when no read was issued.
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
                rd_v <= 1'b0;
            end else begin
                rd_q <= mem[mem_addr_o];
                rd_v <= 1'b1;
            end
        end else begin
            rd_v <= 1'b0;
        end
    end
    assign mem_rdata = rd_v ? rd_q : 32'hBADB_AD00;

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 10'h004;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 10'h020; d_wdata = 32'h1234_5678;
        #2;
        checks++; if (if_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_if_gnt: got %b expected 0", if_gnt_o); end
        checks++; if (d_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_d_gnt: got %b expected 0", d_gnt_o); end
        checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we_o); end
        checks++; if (if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", if_rvalid_o, d_rvalid_o); end
        checks++; if (if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", if_rdata_o, d_rdata_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem_en_o !== 1'b0 || if_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_held: got en=%b rvalid=%b expected 0 0", mem_en_o, if_rvalid_o); end
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_if_stream();
        for (int i = 0; i < 4; i++) begin
            if_req = (i < 3); if_addr = 10'(4 + i);
            @(negedge clk);
            checks++; if (if_gnt_o !== (i < 3)) begin errors++; $display("FAIL if_stream_gnt[%0d]: got %b expected %b", i, if_gnt_o, (i < 3)); end
            checks++; if (if_rvalid_o !== (i > 0)) begin errors++; $display("FAIL if_stream_rvalid[%0d]: got %b expected %b", i, if_rvalid_o, (i > 0)); end
            if (i > 0) begin
                checks++; if (if_rdata_o !== 32'hA000_0003 + 32'(i)) begin errors++; $display("FAIL if_stream_rdata[%0d]: got %h expected %h", i, if_rdata_o, 32'hA000_0003 + 32'(i)); end
            end
            if (i == 0) begin
                checks++; if (mem_addr_o !== 10'h004 || mem_en_o !== 1'b1) begin errors++; $display("FAIL if_stream_mem: got en=%b addr=%h expected 1 004", mem_en_o, mem_addr_o); end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (if_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL if_stream_end: got rvalid=%b busy=%b expected 0 0", if_rvalid_o, busy_o); end
        checks++; if (if_rdata_o !== 32'hA000_0006) begin errors++; $display("FAIL if_stream_hold: got %h expected a0000006", if_rdata_o); end
        next_cycle();
    endtask

    task automatic test_first_conflict();
        apply_reset();
        if_req = 1'b1; if_addr = 10'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h200;
        @(negedge clk);
        checks++; if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin errors++; $display("FAIL conflict_c1_gnt: got d=%b if=%b expected 1 0", d_gnt_o, if_gnt_o); end
        checks++; if (mem_addr_o !== 10'h200 || mem_we_o !== 1'b0) begin errors++; $display("FAIL conflict_c1_mem: got addr=%h we=%b expected 200 0", mem_addr_o, mem_we_o); end
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (if_gnt_o !== 1'b1 || d_gnt_o !== 1'b0) begin errors++; $display("FAIL conflict_c2_gnt: got if=%b d=%b expected 1 0", if_gnt_o, d_gnt_o); end
        checks++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hA000_0200) begin errors++; $display("FAIL conflict_c2_d_resp: got %b %h expected 1 a0000200", d_rvalid_o, d_rdata_o); end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hA000_0010) begin errors++; $display("FAIL conflict_c3_if_resp: got %b %h expected 1 a0000010", if_rvalid_o, if_rdata_o); end
        checks++; if (d_rvalid_o !== 1'b0) begin errors++; $display("FAIL conflict_c3_d_rvalid: got %b expected 0", d_rvalid_o); end
        next_cycle();
    endtask

    task automatic test_alternate();
        apply_reset();
        if_req = 1'b1; if_addr = 10'h008;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (d_gnt_o !== (i % 2 == 0) || if_gnt_o !== (i % 2 == 1)) begin errors++; $display("FAIL alternate[%0d]: got d=%b if=%b expected %b %b", i, d_gnt_o, if_gnt_o, (i % 2 == 0), (i % 2 == 1)); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_write_read();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 10'h020; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (d_gnt_o !== 1'b1 || mem_en_o !== 1'b1 || mem_we_o !== 1'b1) begin errors++; $display("FAIL wr_strobe: got gnt=%b en=%b we=%b expected 1 1 1", d_gnt_o, mem_en_o, mem_we_o); end
        checks++; if (mem_be_o !== 4'b0011 || mem_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_payload: got be=%b wdata=%h expected 0011 deadbeef", mem_be_o, mem_wdata_o); end
        next_cycle();
        d_we = 1'b0;
        @(negedge clk);
        checks++; if (d_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got rvalid=%b busy=%b expected 0 0", d_rvalid_o, busy_o); end
        checks++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'b1111) begin errors++; $display("FAIL rd_strobe: got we=%b be=%b expected 0 1111", mem_we_o, mem_be_o); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h1122_BEEF) begin errors++; $display("FAIL rd_after_wr: got %b %h expected 1 1122beef", d_rvalid_o, d_rdata_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h1122_BEEF) begin errors++; $display("FAIL d_hold: got %b %h expected 0 1122beef", d_rvalid_o, d_rdata_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        if_req = 1'b1; if_addr = 10'h004;
        @(negedge clk);
        checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL midrst_gnt: got %b expected 1", if_gnt_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (if_gnt_o !== 1'b0 || mem_en_o !== 1'b0) begin errors++; $display("FAIL midrst_forced: got gnt=%b en=%b expected 0 0", if_gnt_o, mem_en_o); end
        checks++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0) begin errors++; $display("FAIL midrst_outputs: got %b %h %h expected 0 0 0", if_rvalid_o, if_rdata_o, d_rdata_o); end
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++; if (if_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL midrst_discard: got rvalid=%b busy=%b expected 0 0", if_rvalid_o, busy_o); end
        next_cycle();
        if_req = 1'b1; if_addr = 10'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h200;
        @(negedge clk);
        checks++; if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin errors++; $display("FAIL midrst_conflict: got d=%b if=%b expected 1 0", d_gnt_o, if_gnt_o); end
        next_cycle();
        idle_inputs();
        repeat (2) next_cycle();
    endtask

    task automatic test_idle_hold();
        if_req = 1'b1; if_addr = 10'h030;
        @(negedge clk);
        checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL hold_gnt: got %b expected 1", if_gnt_o); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL hold_resp: got %b %h expected 1 cafef00d", if_rvalid_o, if_rdata_o); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_en_o !== 1'b0 || busy_o !== 1'b0 || if_rvalid_o !== 1'b0) begin errors++; $display("FAIL idle[%0d]: got en=%b busy=%b rvalid=%b expected 0 0 0", i, mem_en_o, busy_o, if_rvalid_o); end
            checks++; if (if_rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL idle_hold[%0d]: got %h expected cafef00d", i, if_rdata_o); end
            next_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[10'h020] = 32'h1122_3344;
        mem[10'h030] = 32'hCAFE_F00D;
        test_reset();
        test_if_stream();
        test_first_conflict();
        test_alternate();
        test_write_read();
        test_reset_mid_read();
        test_idle_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
